// File: rtl/fire_alarm_pkg.sv
// Shared types and default configuration for the per-zone fire alarm controller.
package fire_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    FIRE = 2'd2
  } zone_state_t;

  localparam int unsigned DEF_ZONES        = 4;
  localparam int unsigned DEF_DEBOUNCE     = 4;
  localparam int unsigned DEF_PREALARM_CYC = 8;
  localparam int unsigned DEF_HOLD_CYC     = 6;

endpackage

// File: rtl/fire_zone_fsm.sv
// One fire zone: sensor debounce, pre-alarm countdown, discharge hold and state machine.
// ALARM_LATCH_EN: FIRE persists until clear instead of ending after a low-sensor hold.
module fire_zone_fsm
  import fire_alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned PREALARM_CYC = DEF_PREALARM_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic fire_sensor,
  input  logic abort,
`ifdef ALARM_LATCH_EN
  input  logic clear,
`endif
  output logic extinguisher,
  output logic active
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned PW = $clog2(PREALARM_CYC + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREALARM_CYC);

  zone_state_t   state, state_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [PW-1:0] pre_cnt, pre_n;
  logic          lock, lock_n;

`ifndef ALARM_LATCH_EN
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  logic [HW-1:0] hold_cnt, hold_n;
`endif

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    lock_n  = lock;
`ifndef ALARM_LATCH_EN
    hold_n  = hold_cnt;
`endif
    deb_n = fire_sensor ? ((deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DW'(1)) : '0;

    case (state)
      IDLE: begin
        // An aborted zone must see the sensor drop before it may re-arm.
        if (lock) begin
          if (!fire_sensor) lock_n = 1'b0;
        end else if (fire_sensor && deb_n == DEB_MAX) begin
          state_n = PRE;
          pre_n   = PRE_MAX;
        end
      end
      PRE: begin
        if (abort) begin
          state_n = IDLE;
          pre_n   = '0;
          lock_n  = fire_sensor;
        end else if (!fire_sensor) begin
          state_n = IDLE;
          pre_n   = '0;
        end else if (pre_cnt == PW'(1)) begin
          state_n = FIRE;
          pre_n   = '0;
`ifndef ALARM_LATCH_EN
          hold_n  = '0;
`endif
        end else begin
          pre_n = pre_cnt - PW'(1);
        end
      end
      FIRE: begin
`ifdef ALARM_LATCH_EN
        if (clear) state_n = IDLE;
`else
        if (fire_sensor) begin
          hold_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = IDLE;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      deb_cnt      <= '0;
      pre_cnt      <= '0;
      lock         <= 1'b0;
      extinguisher <= 1'b0;
      active       <= 1'b0;
`ifndef ALARM_LATCH_EN
      hold_cnt     <= '0;
`endif
    end else begin
      state        <= state_n;
      deb_cnt      <= deb_n;
      pre_cnt      <= pre_n;
      lock         <= lock_n;
      extinguisher <= (state_n == FIRE);
      active       <= (state_n != IDLE);
`ifndef ALARM_LATCH_EN
      hold_cnt     <= hold_n;
`endif
    end
  end

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Multi-zone fire alarm controller: one independent zone FSM per sensor, combined alarms.
// ALARM_LATCH_EN: discharge latches until the global clear input is pulsed.
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int unsigned ZONES        = DEF_ZONES,
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned PREALARM_CYC = DEF_PREALARM_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ZONES-1:0] fire_sensor,
  input  logic [ZONES-1:0] abort,
  input  logic             clear,
  output logic [ZONES-1:0] extinguisher,
  output logic             buzzer,
  output logic             fire_any
);

  logic [ZONES-1:0] active;

`ifndef ALARM_LATCH_EN
  logic unused_clear;
  assign unused_clear = clear;
`endif

  for (genvar g = 0; g < ZONES; g++) begin : g_zone
    fire_zone_fsm #(
      .DEBOUNCE    (DEBOUNCE),
      .PREALARM_CYC(PREALARM_CYC),
      .HOLD_CYC    (HOLD_CYC)
    ) u_zone (
      .clk         (clk),
      .reset       (reset),
      .fire_sensor (fire_sensor[g]),
      .abort       (abort[g]),
`ifdef ALARM_LATCH_EN
      .clear       (clear),
`endif
      .extinguisher(extinguisher[g]),
      .active      (active[g])
    );
  end

  // Per-zone flags are already registered; the OR adds no state.
  assign buzzer   = |active;
  assign fire_any = |extinguisher;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Self-checking bench for fire_alarm_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_fire_alarm_ctrl;

  localparam int unsigned ZONES        = 4;
  localparam int unsigned DEBOUNCE     = 4;
  localparam int unsigned PREALARM_CYC = 8;
  localparam int unsigned HOLD_CYC     = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [ZONES-1:0] sensor;
  logic [ZONES-1:0] abort;
  logic             clear;
  logic [ZONES-1:0] extinguisher;
  logic             buzzer;
  logic             fire_any;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Reference model: per zone, phase 0 = quiet, 1 = pre-alarm, 2 = discharging.
  int highs    [ZONES];
  int phase    [ZONES];
  int pre_time [ZONES];
  int lows     [ZONES];
  bit locked   [ZONES];

  fire_alarm_ctrl #(
    .ZONES       (ZONES),
    .DEBOUNCE    (DEBOUNCE),
    .PREALARM_CYC(PREALARM_CYC),
    .HOLD_CYC    (HOLD_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fire_sensor (sensor),
    .abort       (abort),
    .clear       (clear),
    .extinguisher(extinguisher),
    .buzzer      (buzzer),
    .fire_any    (fire_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int z = 0; z < ZONES; z++) begin
      if (reset) begin
        highs[z] = 0; phase[z] = 0; pre_time[z] = 0; lows[z] = 0; locked[z] = 1'b0;
      end else begin
        bit s, a;
        s = sensor[z];
        a = abort[z];
        highs[z] = s ? ((highs[z] < int'(DEBOUNCE)) ? highs[z] + 1 : highs[z]) : 0;
        case (phase[z])
          0: begin
            if (locked[z]) begin
              if (!s) locked[z] = 1'b0;
            end else if (highs[z] >= int'(DEBOUNCE)) begin
              phase[z] = 1; pre_time[z] = 0;
            end
          end
          1: begin
            pre_time[z]++;
            if (a) begin
              phase[z] = 0; locked[z] = s;
            end else if (!s) begin
              phase[z] = 0;
            end else if (pre_time[z] == int'(PREALARM_CYC)) begin
              phase[z] = 2; lows[z] = 0;
            end
          end
          default: begin
`ifdef ALARM_LATCH_EN
            if (clear) phase[z] = 0;
`else
            lows[z] = s ? 0 : lows[z] + 1;
            if (lows[z] == int'(HOLD_CYC)) phase[z] = 0;
`endif
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [ZONES-1:0] exp_ext;
      logic exp_buz, exp_fire;
      exp_ext = '0; exp_buz = 1'b0; exp_fire = 1'b0;
      for (int z = 0; z < ZONES; z++) begin
        exp_ext[z] = (phase[z] == 2);
        if (phase[z] != 0) exp_buz = 1'b1;
        if (phase[z] == 2) exp_fire = 1'b1;
      end
      check("model_ext", 32'(extinguisher), 32'(exp_ext));
      check("model_buzzer", 32'(buzzer), 32'(exp_buz));
      check("model_fire_any", 32'(fire_any), 32'(exp_fire));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sensor = '0; abort = '0; clear = 1'b0;
    step(2);
    model_on = 1'b1;
    check("rst_ext", 32'(extinguisher), 32'h0);
    check("rst_buzzer", 32'(buzzer), 32'h0);
    check("rst_fire_any", 32'(fire_any), 32'h0);
    reset = 1'b0;

    // Continuous fire on zone 0
    sensor = 4'b0001;
    step(3); check("z0_buz_edge3", 32'(buzzer), 32'h0);
    step(1); check("z0_buz_edge4", 32'(buzzer), 32'h1);
    check("z0_ext_edge4", 32'(extinguisher), 32'h0);
    step(7); check("z0_ext_edge11", 32'(extinguisher), 32'h0);
    step(1); check("z0_ext_edge12", 32'(extinguisher), 32'h1);
    check("z0_fire_any", 32'(fire_any), 32'h1);
    sensor = '0;
    step(5); check("z0_hold5", 32'(extinguisher), 32'h1);
    step(1);
`ifdef ALARM_LATCH_EN
    check("z0_latched", 32'(extinguisher), 32'h1);
    clear = 1'b1; step(1); clear = 1'b0;
    check("z0_cleared", 32'(extinguisher), 32'h0);
`else
    check("z0_hold6", 32'(extinguisher), 32'h0);
`endif

    // Bouncing sensor on zone 1
    sensor = 4'b0010; step(3);
    sensor = '0;      step(1);
    sensor = 4'b0010; step(3);
    check("z1_bounce_buz", 32'(buzzer), 32'h0);
    sensor = '0;      step(1);

    // Abort during pre-alarm on zone 2
    sensor = 4'b0100; step(4);
    check("z2_pre", 32'(buzzer), 32'h1);
    step(4);
    abort = 4'b0100; step(1); abort = '0;
    check("z2_abort", 32'(buzzer), 32'h0);
    step(10);
    check("z2_locked_buz", 32'(buzzer), 32'h0);
    check("z2_locked_ext", 32'(extinguisher), 32'h0);
    sensor = '0; step(1);
    sensor = 4'b0100; step(3);
    check("z2_rearm3", 32'(buzzer), 32'h0);
    step(1);
    check("z2_rearm4", 32'(buzzer), 32'h1);
    sensor = '0; step(1);
    check("z2_drop", 32'(buzzer), 32'h0);

    // Hold counter restart on zone 3
    sensor = 4'b1000; step(12);
    check("z3_fire", 32'(extinguisher), 32'h8);
    sensor = '0;      step(5);
    sensor = 4'b1000; step(1);
    sensor = '0;      step(5);
    check("z3_low5", 32'(extinguisher), 32'h8);
    step(1);
`ifdef ALARM_LATCH_EN
    check("z3_latched", 32'(extinguisher), 32'h8);
    clear = 1'b1; step(1); clear = 1'b0;
    check("z3_cleared", 32'(extinguisher), 32'h0);
`else
    check("z3_low6", 32'(extinguisher), 32'h0);
`endif

    // Reset during discharge on zones 0 and 1
    sensor = 4'b0011; step(12);
    check("z01_fire", 32'(extinguisher), 32'h3);
    reset = 1'b1; step(1); reset = 1'b0;
    check("z01_rst_ext", 32'(extinguisher), 32'h0);
    check("z01_rst_buz", 32'(buzzer), 32'h0);
    check("z01_rst_fire", 32'(fire_any), 32'h0);
    step(3); check("z01_redeb3", 32'(buzzer), 32'h0);
    step(1); check("z01_redeb4", 32'(buzzer), 32'h1);
    sensor = '0; step(1);
    check("z01_drop", 32'(buzzer), 32'h0);

    // Randomized traffic with long sensor runs
    for (int c = 0; c < 4000; c++) begin
      for (int z = 0; z < ZONES; z++) begin
        if ($urandom_range(15) == 0) sensor[z] = ~sensor[z];
        abort[z] = ($urandom_range(47) == 0);
      end
      clear = ($urandom_range(63) == 0);
      reset = ($urandom_range(699) == 0);
      step(1);
    end
    reset = 1'b0; abort = '0; clear = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_alarm_ctrl.md
FIRE_ALARM_CTRL -- requirements
Module: fire_alarm_ctrl

Interface
REQ-001 Parameter ZONES, default 4, number of independent fire zones (1..16).
REQ-002 Parameter DEBOUNCE, default 4, consecutive high samples needed to accept a sensor (>=1).
REQ-003 Parameter PREALARM_CYC, default 8, pre-alarm duration in cycles before discharge (>=1).
REQ-004 Parameter HOLD_CYC, default 6, consecutive low-sensor cycles before discharge stops (>=1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 fire_sensor  input  ZONES  per-zone sensor, synchronous to clk, high = fire.
REQ-008 abort  input  ZONES  per-zone manual abort, effective only in pre-alarm.
REQ-009 clear  input  1  global latch clear, used only when ALARM_LATCH_EN is defined.
REQ-010 extinguisher  output  ZONES  per-zone discharge enable, registered.
REQ-011 buzzer  output  1  high while any zone is in PRE or FIRE, registered.
REQ-012 fire_any  output  1  high while any zone is in FIRE, registered.

Function
REQ-013 Each zone SHALL run an independent FSM with states IDLE, PRE, FIRE.
REQ-014 Debounce counter SHALL increment each cycle fire_sensor[i]=1, clear to 0 on any low sample, saturate at DEBOUNCE.
REQ-015 IDLE->PRE SHALL occur on the edge where the DEBOUNCE-th consecutive high sample is taken.
REQ-016 On entering PRE, a countdown SHALL load PREALARM_CYC; PRE->FIRE on the edge it reaches 0, i.e. exactly PREALARM_CYC cycles in PRE.
REQ-017 In PRE, abort[i]=1 or fire_sensor[i]=0 SHALL return to IDLE next edge; abort wins over a simultaneous timeout.
REQ-018 After an abort, the zone SHALL stay in IDLE until fire_sensor[i] has been sampled low at least once, then re-debounce.
REQ-019 In FIRE, extinguisher[i]=1; abort[i] SHALL be ignored.
REQ-020 In FIRE (latch disabled), a hold counter SHALL count consecutive low samples, reset on any high sample; FIRE->IDLE when it reaches HOLD_CYC.
REQ-021 extinguisher, buzzer, fire_any SHALL be registered from next-state, changing on the same edge as the state.
REQ-022 Counter widths SHALL be $clog2(max value+1); no counter SHALL wrap.
REQ-023 Zones SHALL not interact; simultaneous events in several zones SHALL be handled in the same cycle.

Reset
REQ-024 reset=1 SHALL force all zones to IDLE, zero all counters and abort-lock flags, and drive extinguisher=0, buzzer=0, fire_any=0 on that edge.
REQ-025 reset SHALL take priority over every input, including mid-discharge and mid-pre-alarm.

Configuration
REQ-026 Macro ALARM_LATCH_EN: when defined, FIRE SHALL persist regardless of sensor level until clear=1, which returns all FIRE zones to IDLE next edge; the hold counter is omitted.
REQ-027 Without ALARM_LATCH_EN, clear SHALL be ignored and FIRE exit SHALL follow REQ-020.

Structure
REQ-028 Package fire_alarm_pkg SHALL hold the zone state enum (IDLE, PRE, FIRE) and default parameter constants.
REQ-029 Sub-module fire_zone_fsm SHALL implement one zone (debounce, countdown, hold, FSM), instantiated ZONES times by generate; top ORs buzzer/fire_any.

Verification (defaults ZONES=4, DEBOUNCE=4, PREALARM_CYC=8, HOLD_CYC=6)
REQ-030 Sensor[0] high continuously from cycle 0 -> buzzer=1 after edge 4, extinguisher[0]=1 after edge 12, others 0.
REQ-031 Sensor[1] high 3 cycles, low 1, high 3 -> no state change, buzzer stays 0.
REQ-032 Sensor[2] high, abort[2] pulse at PRE cycle 5 -> IDLE next edge, extinguisher[2] never asserts, stays IDLE until sensor drops.
REQ-033 Zone 3 in FIRE, sensor low 5 cycles, high 1, low 6 -> extinguisher[3] drops after 6th low of second run (latch off); with ALARM_LATCH_EN stays 1 until clear pulse.
REQ-034 Zones 0 and 1 in FIRE, reset pulse 1 cycle -> all outputs 0 next edge; sensors still high -> re-debounce 4 cycles then PRE.
